// File: rtl/line_sched_pkg.sv
// Shared types and constants for the line-engine scheduler.
package line_sched_pkg;

   // Width of grant_id / round-robin pointer (covers up to 8 requesters).
   localparam int GID_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/line_rr_arbiter.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module line_rr_arbiter
   import line_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   last,
   output logic               gnt_valid,
   output logic [GID_W-1:0]   gnt_idx
);

   // Scan from farthest to nearest so the nearest candidate after 'last' wins.
   always_comb begin
      int idx;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = GID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/line_scheduler.sv
// Round-robin sharing of one line-drawing engine among NUM_REQ requesters.
// Latches the winner's command, pulses start, tracks engine busy to completion,
// then pulses done for that requester and bumps the completed-line counter.
module line_scheduler
   import line_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH_BITS  = 6,
   parameter int COLOR_BITS  = 8,
   parameter int ARM_TIMEOUT = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*WIDTH_BITS-1:0]  cmd_x0,
   input  logic [NUM_REQ*WIDTH_BITS-1:0]  cmd_y0,
   input  logic [NUM_REQ*WIDTH_BITS-1:0]  cmd_x1,
   input  logic [NUM_REQ*WIDTH_BITS-1:0]  cmd_y1,
   input  logic [NUM_REQ*COLOR_BITS-1:0]  cmd_color,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             done,
   output logic [WIDTH_BITS-1:0]          line_x0,
   output logic [WIDTH_BITS-1:0]          line_y0,
   output logic [WIDTH_BITS-1:0]          line_x1,
   output logic [WIDTH_BITS-1:0]          line_y1,
   output logic [COLOR_BITS-1:0]          line_color,
   output logic                           line_start,
   input  logic                           line_busy,
   output logic [GID_W-1:0]               grant_id,
   output logic                           idle,
   output logic [31:0]                    lines_drawn,
   output logic                           timeout_err
);

   localparam int CW = $clog2(ARM_TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [GID_W-1:0] last;
   logic [CW-1:0]    cnt;
   logic             gnt_valid;
   logic [GID_W-1:0] gnt_idx;
   logic             do_grant, do_finish, arm_to;

   line_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign idle = (state == IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic plus the grant / finish / timeout events for this edge.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_finish = 1'b0;
      arm_to    = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && !line_busy && gnt_valid) begin
               do_grant  = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (line_busy) begin
               state_nxt = RUN;
            end else if (cnt == CW'(ARM_TIMEOUT - 1)) begin
               arm_to    = 1'b1;
               do_finish = 1'b1;
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (!line_busy) begin
               do_finish = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs: pulses default low, command held until the next grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack         <= '0;
         done        <= '0;
         line_start  <= 1'b0;
         line_x0     <= '0;
         line_y0     <= '0;
         line_x1     <= '0;
         line_y1     <= '0;
         line_color  <= '0;
         grant_id    <= '0;
         last        <= GID_W'(NUM_REQ - 1);
         cnt         <= '0;
         lines_drawn <= '0;
         timeout_err <= 1'b0;
      end else begin
         ack        <= '0;
         done       <= '0;
         line_start <= 1'b0;
         if (do_grant) begin
            line_x0    <= cmd_x0[int'(gnt_idx)*WIDTH_BITS +: WIDTH_BITS];
            line_y0    <= cmd_y0[int'(gnt_idx)*WIDTH_BITS +: WIDTH_BITS];
            line_x1    <= cmd_x1[int'(gnt_idx)*WIDTH_BITS +: WIDTH_BITS];
            line_y1    <= cmd_y1[int'(gnt_idx)*WIDTH_BITS +: WIDTH_BITS];
            line_color <= cmd_color[int'(gnt_idx)*COLOR_BITS +: COLOR_BITS];
            ack        <= NUM_REQ'(1) << gnt_idx;
            line_start <= 1'b1;
            grant_id   <= gnt_idx;
            last       <= gnt_idx;
            cnt        <= '0;
         end
         if (state == ARM && !line_busy && !arm_to)
            cnt <= cnt + 1'b1;
         if (arm_to)
            timeout_err <= 1'b1;
         if (do_finish) begin
            done        <= NUM_REQ'(1) << grant_id;
            lines_drawn <= lines_drawn + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler: a transaction-level model of the
// scheduler rules is checked every cycle, plus hand-computed literal checks.
module tb_line_scheduler;

   localparam int N = 4;
   localparam int W = 6;
   localparam int C = 8;
   localparam int T = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           enable = 1'b0;
   logic           line_busy = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [N*C-1:0] cmd_color = '0;
   logic [N-1:0]   ack, done;
   logic [W-1:0]   line_x0, line_y0, line_x1, line_y1;
   logic [C-1:0]   line_color;
   logic           line_start, idle, timeout_err;
   logic [2:0]     grant_id;
   logic [31:0]    lines_drawn;

   line_scheduler #(.NUM_REQ(N), .WIDTH_BITS(W), .COLOR_BITS(C), .ARM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
      .cmd_color(cmd_color), .ack(ack), .done(done),
      .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
      .line_color(line_color), .line_start(line_start), .line_busy(line_busy),
      .grant_id(grant_id), .idle(idle), .lines_drawn(lines_drawn),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- engine: busy for eng_len cycles after a start pulse
   int eng_len   = 3;
   bit eng_never = 1'b0;
   initial begin
      bit st;
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         st = (line_start === 1'b1) && reset;
         @(posedge clk);
         #2;
         if (!reset) begin
            line_busy = 1'b0;
            t = 0;
         end else if (st && !eng_never) begin
            line_busy = 1'b1;
            t = eng_len;
         end else if (t > 0) begin
            t--;
            if (t == 0) line_busy = 1'b0;
         end
      end
   end

   // ---------------- reference model of the scheduling rules
   int           m_phase = 0;   // 0 free, 1 waiting for busy, 2 drawing, 3 reporting done
   int           m_wait = 0;
   int           m_last = N-1;
   int           m_gid = 0;
   int           m_g = 0;
   logic [W-1:0] m_x0 = '0, m_y0 = '0, m_x1 = '0, m_y1 = '0;
   logic [C-1:0] m_col = '0;
   logic [31:0]  m_cnt = '0;
   logic         m_terr = 1'b0;
   logic [N-1:0] e_ack, e_done;
   logic         e_start;
   logic         p_rst = 1'b0, p_en = 1'b0, p_busy = 1'b0;
   logic [N-1:0] p_req = '0;
   logic [N-1:0] last_ack = '0;
   int           grants[$];

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      e_ack   = '0;
      e_done  = '0;
      e_start = 1'b0;
      if (!reset || !p_rst) begin
         m_phase = 0; m_wait = 0; m_last = N-1; m_gid = 0;
         m_x0 = '0; m_y0 = '0; m_x1 = '0; m_y1 = '0; m_col = '0;
         m_cnt = '0; m_terr = 1'b0;
      end else begin
         case (m_phase)
            0: if (p_en && !p_busy) begin
                  m_g = rr_pick(p_req, m_last);
                  if (m_g >= 0) begin
                     m_last = m_g; m_gid = m_g;
                     m_x0 = cmd_x0[m_g*W +: W]; m_y0 = cmd_y0[m_g*W +: W];
                     m_x1 = cmd_x1[m_g*W +: W]; m_y1 = cmd_y1[m_g*W +: W];
                     m_col = cmd_color[m_g*C +: C];
                     e_ack[m_g] = 1'b1; e_start = 1'b1;
                     m_wait = 0; m_phase = 1;
                  end
               end
            1: if (p_busy) m_phase = 2;
               else if (m_wait == T-1) begin
                  m_terr = 1'b1; e_done[m_gid] = 1'b1; m_cnt++; m_phase = 3;
               end else m_wait++;
            2: if (!p_busy) begin
                  e_done[m_gid] = 1'b1; m_cnt++; m_phase = 3;
               end
            default: m_phase = 0;
         endcase
      end
      chk("ack",         32'(ack),         32'(e_ack));
      chk("done",        32'(done),        32'(e_done));
      chk("line_start",  32'(line_start),  32'(e_start));
      chk("line_x0",     32'(line_x0),     32'(m_x0));
      chk("line_y0",     32'(line_y0),     32'(m_y0));
      chk("line_x1",     32'(line_x1),     32'(m_x1));
      chk("line_y1",     32'(line_y1),     32'(m_y1));
      chk("line_color",  32'(line_color),  32'(m_col));
      chk("grant_id",    32'(grant_id),    32'(m_gid));
      chk("idle",        32'(idle),        32'(m_phase == 0));
      chk("lines_drawn", lines_drawn,      m_cnt);
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      for (int i = 0; i < N; i++) if (ack[i]) grants.push_back(i);
      last_ack = ack;
      p_rst  = reset;
      p_en   = enable;
      p_busy = line_busy;
      p_req  = req;
   end

   // ---------------- driver helpers
   logic [N-1:0] persist = '0;

   // Advance one cycle; requesters drop req the edge after their ack.
   task automatic tick();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++)
         if (last_ack[i] && !persist[i]) req[i] = 1'b0;
   endtask

   task automatic wait_grants(input string name, input int target, input int limit);
      int k;
      k = 0;
      while (!(grants.size() >= target && idle && req == '0) && k < limit) begin
         tick();
         k++;
      end
      if (k >= limit) chk({name, "_bound"}, 32'(k), 32'(0));
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      while (!idle && k < limit) begin tick(); k++; end
      if (k >= limit) chk("idle_bound", 32'(k), 32'(0));
   endtask

   initial begin
      int gs, k, acks;
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int gs, k, acks;
      // Commands: requester 0 = (1,2,40,30,5A); others distinct.
      cmd_x0    = {6'd11, 6'd7, 6'd3, 6'd1};
      cmd_y0    = {6'd12, 6'd8, 6'd4, 6'd2};
      cmd_x1    = {6'd13, 6'd9, 6'd5, 6'd40};
      cmd_y1    = {6'd14, 6'd10, 6'd6, 6'd30};
      cmd_color = {8'h33, 8'h22, 8'h11, 8'h5A};

      // Reset state
      repeat (3) tick();
      chk("rst_lines", lines_drawn, 32'd0);
      chk("rst_idle",  32'(idle),   32'd1);
      chk("rst_ack",   32'(ack),    32'd0);
      reset  = 1'b1;
      enable = 1'b1;
      tick();

      // Contention: all four request, expected order 0,1,2,3
      eng_len = 1;
      gs  = grants.size();
      req = 4'b1111;
      wait_grants("cont", gs + 4, 200);
      for (int i = 0; i < 4; i++)
         chk("cont_order", 32'(grants.size() > gs+i ? grants[gs+i] : -1), 32'(i));
      chk("cont_lines", lines_drawn, 32'd4);

      // Single request with a 10-cycle engine
      eng_len = 10;
      req = 4'b0001;
      tick();
      chk("s_ack",   32'(ack),        32'b0001);
      chk("s_start", 32'(line_start), 32'd1);
      chk("s_x0",    32'(line_x0),    32'd1);
      chk("s_y1",    32'(line_y1),    32'd30);
      chk("s_color", 32'(line_color), 32'h5A);
      k = 0;
      while (done == '0 && k < 40) begin tick(); k++; end
      chk("s_done",  32'(done),  32'b0001);
      chk("s_lines", lines_drawn, 32'd5);
      wait_idle(20);

      // Fairness: requesters 1 and 2 held high -> 1,2,1,2
      eng_len = 2;
      gs = grants.size();
      persist = 4'b0110;
      req = 4'b0110;
      k = 0;
      while (grants.size() < gs + 4 && k < 200) begin tick(); k++; end
      persist = '0;
      req = '0;
      wait_idle(40);
      chk("fair_g0", 32'(grants.size() > gs   ? grants[gs]   : -1), 32'd1);
      chk("fair_g1", 32'(grants.size() > gs+1 ? grants[gs+1] : -1), 32'd2);
      chk("fair_g2", 32'(grants.size() > gs+2 ? grants[gs+2] : -1), 32'd1);
      chk("fair_g3", 32'(grants.size() > gs+3 ? grants[gs+3] : -1), 32'd2);

      // Enable gating
      enable = 1'b0;
      req = 4'b0100;
      acks = 0;
      repeat (20) begin tick(); if (ack != '0) acks++; end
      chk("gate_noack", 32'(acks), 32'd0);
      enable = 1'b1;
      tick();
      chk("gate_ack", 32'(ack), 32'b0100);
      wait_idle(40);

      // Timeout: engine never goes busy
      eng_never = 1'b1;
      req = 4'b0001;
      tick();
      chk("to_ack", 32'(ack), 32'b0001);
      k = 0;
      while (done == '0 && k < 20) begin tick(); k++; end
      chk("to_lat",   32'(k),           32'(T));
      chk("to_done",  32'(done),        32'b0001);
      chk("to_err",   32'(timeout_err), 32'd1);
      chk("to_lines", lines_drawn,      32'd11);
      eng_never = 1'b0;
      wait_idle(20);

      // Reset mid-RUN abandons the line
      eng_len = 10;
      req = 4'b0001;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("mr_lines", lines_drawn,      32'd0);
      chk("mr_done",  32'(done),        32'd0);
      chk("mr_err",   32'(timeout_err), 32'd0);
      chk("mr_x0",    32'(line_x0),     32'd0);
      chk("mr_idle",  32'(idle),        32'd1);
      repeat (3) tick();
      reset = 1'b1;
      req = 4'b1001;
      gs = grants.size();
      tick();
      chk("mr_first", 32'(ack), 32'b0001);
      wait_grants("mr", gs + 2, 200);
      chk("mr_second", 32'(grants.size() > gs+1 ? grants[gs+1] : -1), 32'd3);
      chk("mr_count",  lines_drawn, 32'd2);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
